// File: rtl/spike_label_collector_pkg.sv
// Shared widths and the leaf-label function for the spike label collector.
// Widths here match the default tree and channel parameters.
package spike_label_collector_pkg;

    localparam int DEF_FEATURES      = 3;
    localparam int DEF_CHANNEL_COUNT = 16;
    localparam int LW                = $clog2(DEF_FEATURES);
    localparam int PW                = LW;
    localparam int CW                = $clog2(DEF_CHANNEL_COUNT);
    localparam int LABEL_W           = LW + PW;

    // Path bits past the final depth are stale, so they are masked off.
    // Otherwise two visits to the same leaf could produce different labels.
    function automatic logic [LABEL_W-1:0] label_of(input logic [LW-1:0] level,
                                                     input logic [PW-1:0] path);
        logic [PW-1:0] mask;
        mask = '0;
        for (int i = 0; i < PW; i++) begin
            mask[i] = (i <= int'(level));
        end
        return {level, path & mask};
    endfunction

endpackage

// File: rtl/spike_label_collector_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// The head entry is visible whenever the FIFO is not empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Gate the head while empty so stale memory contents never show on the outputs.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spike_label_collector.sv
// Turns finished tree classifications into channel-tagged cluster labels,
// buffers them for readout and keeps saturating per-label diagnostics.
module spike_label_collector
    import spike_label_collector_pkg::*;
#(
    parameter int FEATURES      = DEF_FEATURES,
    parameter int CHANNEL_COUNT = DEF_CHANNEL_COUNT,
    parameter int FIFO_DEPTH    = 8,
    parameter int COUNT_W       = 16,
    localparam int LVL_W        = $clog2(FEATURES),
    localparam int PTH_W        = LVL_W,
    localparam int CH_W         = $clog2(CHANNEL_COUNT),
    localparam int LBL_W        = LVL_W + PTH_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [LVL_W-1:0]   level,
    input  logic [PTH_W-1:0]   path,
    input  logic               frame_start,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH_W-1:0]    out_channel,
    output logic [LBL_W-1:0]   out_label,
    input  logic               stats_clear,
    input  logic [LBL_W-1:0]   stat_sel,
    output logic [COUNT_W-1:0] stat_data,
    output logic [COUNT_W-1:0] drop_count,
    output logic               overflow
);

    localparam int ENTRY_W = CH_W + LBL_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int HIST_N  = 1 << LBL_W;

    logic [PTH_W-1:0]   mask;
    logic [LBL_W-1:0]   label;
    logic [CH_W-1:0]    ch;
    logic [CH_W-1:0]    tag;
    logic               push;
    logic               pop;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] head;
    logic [COUNT_W-1:0] hist [HIST_N];

    always_comb begin
        mask = '0;
        for (int i = 0; i < PTH_W; i++) begin
            mask[i] = (i <= int'(level));
        end
    end

    assign label = {level, path & mask};
    assign tag   = frame_start ? '0 : ch;

    always_ff @(posedge clk) begin
        if (reset) begin
            ch <= '0;
        end else if (in_valid) begin
            ch <= (tag == CH_W'(CHANNEL_COUNT - 1)) ? '0 : tag + 1'b1;
        end else if (frame_start) begin
            ch <= '0;
        end
    end

    // A full FIFO still accepts an event when the head leaves in the same cycle.
    assign pop  = out_ready && !fifo_empty;
    assign push = in_valid && ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop);
    assign drop = in_valid && fifo_full && !pop;

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({tag, label}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid                = !fifo_empty;
    assign {out_channel, out_label} = head;

    // Clearing wins over any increment landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || stats_clear) begin
            for (int i = 0; i < HIST_N; i++) begin
                hist[i] <= '0;
            end
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (in_valid && (hist[label] != '1)) begin
                hist[label] <= hist[label] + 1'b1;
            end
            if (drop) begin
                if (drop_count != '1) begin
                    drop_count <= drop_count + 1'b1;
                end
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_data <= '0;
        end else begin
            stat_data <= hist[stat_sel];
        end
    end

endmodule
